// File: rtl/hazard_sched.sv
// hazard_sched: LEGv8 load-use/branch/memory-wait pipeline scheduler; HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_sched #(
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [4:0]  ifid_Rn_i,
  input  logic [4:0]  ifid_Rm_i,
  input  logic        ifid_usesRm_i,
  input  logic        idex_memRead_i,
  input  logic [4:0]  idex_writeReg_i,
  input  logic        exmem_memAccess_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        exmem_flush_o,
  output logic        freeze_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cnt_o
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_trig, w_freeze, w_branch, w_load_use;
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  // hazards outside a freeze stay live in the retire cycle so a branch held in EX/MEM is taken then
  always_comb begin
    w_trig      = r_state == RUN && exmem_memAccess_i && (MEM_LATENCY > 1);
    w_freeze    = w_trig || (r_state == MEM_WAIT && r_cnt != '0);
    w_branch    = !w_freeze && branch_taken_i;
    w_load_use  = !w_freeze && !branch_taken_i && idex_memRead_i && idex_writeReg_i != 5'd31 &&
                  (idex_writeReg_i == ifid_Rn_i || (ifid_usesRm_i && idex_writeReg_i == ifid_Rm_i));
    w_state_nxt = w_trig ? MEM_WAIT : (r_state == MEM_WAIT && r_cnt == '0) ? RUN : r_state;
    w_cnt_nxt   = w_trig ? CNT_W'(MEM_LATENCY - 2) : r_cnt != '0 ? r_cnt - CNT_W'(1) : r_cnt;
  end
  always_comb begin
    pc_write_o    = RESET_N && !w_freeze && !w_load_use;
    ifid_write_o  = RESET_N && !w_freeze && !w_branch && !w_load_use;
    ifid_flush_o  = !RESET_N || w_branch;
    idex_bubble_o = !RESET_N || w_branch || w_load_use;
    exmem_flush_o = !RESET_N || w_branch;
    freeze_o      = RESET_N && w_freeze;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall, r_flush;
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_stall <= r_stall + 32'(w_freeze || w_load_use);
      r_flush <= r_flush + 32'(w_branch);
    end
  assign stall_cycles_o = r_stall;
  assign flush_cnt_o    = r_flush;
`else
  assign stall_cycles_o = '0;
  assign flush_cnt_o    = '0;
`endif
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the five-stage LEGv8 core.
- Sequences the IF/ID, ID/EX and EX/MEM stage registers and the PC each cycle:
  - load-use stall and bubble into ID/EX
  - taken-branch flush of the three younger stages
  - multi-cycle freeze of the whole pipe while data memory completes a variable-latency access
- Sits beside the decode stage; its outputs drive register write-enables and control-zeroing muxes.

Parameters:
- MEM_LATENCY, 3, data-memory access latency in cycles; legal range 1..16.
- CNT_W, 4, width of the memory-wait down-counter; must hold MEM_LATENCY-2.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ifid_Rn_i  in  5  Rn field of the instruction in IF/ID.
- ifid_Rm_i  in  5  Rm field of the instruction in IF/ID.
- ifid_usesRm_i  in  1  instruction in IF/ID reads Rm (R-format, STUR, CBZ data).
- idex_memRead_i  in  1  memRead control of the instruction in ID/EX.
- idex_writeReg_i  in  5  destination register of the instruction in ID/EX.
- exmem_memAccess_i  in  1  memRead or memWrite of the instruction in EX/MEM.
- branch_taken_i  in  1  isBranch AND zero flag, resolved in MEM.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  clear IF/ID to NOP.
- idex_bubble_o  out  1  zero all ID/EX control fields.
- exmem_flush_o  out  1  zero EX/MEM control fields.
- freeze_o  out  1  hold every stage register and the PC.
- stall_cycles_o  out  32  performance: total freeze plus load-use cycles.
- flush_cnt_o  out  32  performance: taken-branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered state, cnt[CNT_W-1:0].
- All control outputs are combinational from state, cnt and inputs; zero-latency to the same cycle.
- While RESET_N=0:
  - state=RUN, cnt=0.
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, freeze=0.
  - perf counters 0.
- Default in RUN with no hazard: pc_write=1, ifid_write=1, all others 0.
- Priority in RUN, highest first: memory wait, branch flush, load-use.
- Memory wait:
  - Trigger: RUN, exmem_memAccess_i=1 and MEM_LATENCY>1.
  - That cycle: freeze=1, pc_write=0, ifid_write=0, flush/bubble=0.
  - Next edge: state->MEM_WAIT, cnt<=MEM_LATENCY-2.
  - In MEM_WAIT with cnt!=0: freeze=1 as above; cnt decrements.
  - In MEM_WAIT with cnt==0: default RUN outputs (the access retires); next edge state->RUN.
  - The access therefore occupies MEM exactly MEM_LATENCY cycles, with MEM_LATENCY-1 frozen.
  - exmem_memAccess_i is ignored in MEM_WAIT, so a held access never retriggers.
  - MEM_LATENCY=1: never freezes; FSM stays RUN.
- Branch flush: RUN, branch_taken_i=1, no freeze.
  - pc_write=1 (target load), ifid_flush=1, idex_bubble=1, exmem_flush=1, ifid_write=0.
  - Single cycle; no state change.
- Load-use: RUN, no freeze, no branch, idex_memRead_i=1, idex_writeReg_i!=31, and either idex_writeReg_i==ifid_Rn_i or (ifid_usesRm_i and idex_writeReg_i==ifid_Rm_i).
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - Clears naturally on the next cycle because the bubble removes the load from ID/EX.
- X31 (XZR) is never a hazard source.
- Branch and memory access in the same cycle is illegal for LEGv8. If it occurs, memory wait wins; the branch is taken when the freeze releases, since EX/MEM held it.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, cnt=0, reset outputs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles_o increments on every cycle with freeze_o=1 or a load-use stall.
  - flush_cnt_o increments on every branch-flush cycle.
  - Both wrap at 2^32; both cleared by reset.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Reset: RESET_N=0 for 3 cycles -> ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=0. After release with no hazards -> pc_write=1, ifid_write=1.
- Load-use: idex_memRead=1, idex_writeReg=5, ifid_Rn=5 -> exactly 1 cycle pc_write=0, ifid_write=0, idex_bubble=1. Repeat with writeReg=31 -> no stall. Repeat with Rm=5, usesRm=0 -> no stall.
- Memory wait, MEM_LATENCY=3: exmem_memAccess=1 held -> freeze=1 for 2 cycles, then 1 unfrozen cycle, then RUN. Back-to-back access -> second wait of 2 more cycles.
- Branch: branch_taken=1 for 1 cycle -> pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1 that cycle only. With the load-use condition also true -> flush outputs win, no stall.
- Reset mid-wait: RESET_N low during the second MEM_WAIT cycle -> state RUN, freeze=0 on release, no residual freeze.
- HAZARD_PERF_CNT_EN: sequence 1 load-use, 1 flush, 1 access at latency 3 -> stall_cycles_o=3, flush_cnt_o=1. Undefined -> both read 0.
